// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider control stage.
package div_ctrl_pkg;
  localparam int DATA_W      = 32;
  localparam int LATENCY_DEF = 4;
  localparam int LAT_MIN     = 1;
  localparam int LAT_MAX     = 15;
  localparam int CNT_W       = 4;   // wide enough for LAT_MAX-1

  localparam logic [DATA_W-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [DATA_W-1:0] DIV0_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CORR, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
  } div_res_t;
endpackage

// File: rtl/div_ctrl_if.sv
// EX-side request/response bus plus the array-divider hookup for div_ctrl.
interface div_ctrl_if;
  logic        start;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [63:0] result;
  logic        arr_en;
  logic [31:0] arr_op1;
  logic [31:0] arr_op2;
  logic [63:0] arr_result;

  // EX stage / array side
  modport master (
    output start, cancel, dividend, divisor, arr_result,
    input  busy, stall_req, done, result, arr_en, arr_op1, arr_op2
  );

  // div_ctrl side
  modport slave (
    input  start, cancel, dividend, divisor, arr_result,
    output busy, stall_req, done, result, arr_en, arr_op1, arr_op2
  );
endinterface

// File: rtl/div_ctrl_fix.sv
// div_fix: combinational sign/remainder correction of the raw array output,
// with the divide-by-zero and INT_MIN/-1 cases forced last.
module div_fix
  import div_ctrl_pkg::*;
(
  input  logic [63:0] i_raw,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [63:0] o_result
);
  logic [31:0] w_rem, w_quo, w_neg_d;
  div_res_t    w_raw;

  assign w_raw   = div_res_t'(i_raw);
  assign w_neg_d = 32'd0 - i_divisor;

  // correct remainder sign, fold |r|==|d| into the quotient, then override
  always_comb begin
    w_rem = w_raw.rem;
    w_quo = w_raw.quo;
    if (w_rem != 32'd0 && w_rem[31] != i_dividend[31]) begin
      if (i_dividend[31] == i_divisor[31]) begin
        w_rem = w_rem + i_divisor;
        w_quo = w_quo - 32'd1;
      end else begin
        w_rem = w_rem - i_divisor;
        w_quo = w_quo + 32'd1;
      end
    end
    // r == d means one more step in the divisor's direction was owed
    if (w_rem == i_divisor) begin
      w_rem = 32'd0;
      w_quo = w_quo + 32'd1;
    end else if (w_rem == w_neg_d) begin
      w_rem = 32'd0;
      w_quo = w_quo - 32'd1;
    end
    if (i_divisor == 32'd0) begin
      w_quo = DIV0_QUO;
      w_rem = i_dividend;
    end else if (i_dividend == INT_MIN && i_divisor == 32'hFFFF_FFFF) begin
      w_quo = INT_MIN;
      w_rem = 32'd0;
    end
    o_result = {w_rem, w_quo};
  end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: drives the multicycle array divider, stalls EX while it settles,
// corrects its raw output and returns {rem, quo} with a one-cycle done pulse.
// Optional macro DIV_BYPASS_EN: trivial operands (d==0, a==0, d==1) finish
// straight from IDLE with done one cycle after start.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF   // array settle cycles, 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  div_ctrl_if.slave  bus
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_op1, r_op2;
  logic [63:0]      r_result;
  logic [63:0]      w_fixed;
  logic             w_accept;
  logic             w_byp;
  logic [63:0]      w_byp_res;

  assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.cancel;

  // trivial-operand shortcut, decided on the live request operands
`ifdef DIV_BYPASS_EN
  always_comb begin
    w_byp     = 1'b1;
    w_byp_res = '0;
    if (bus.divisor == 32'd0)       w_byp_res = {bus.dividend, DIV0_QUO};
    else if (bus.dividend == 32'd0) w_byp_res = '0;
    else if (bus.divisor == 32'd1)  w_byp_res = {32'd0, bus.dividend};
    else                            w_byp     = 1'b0;
  end
`else
  assign w_byp     = 1'b0;
  assign w_byp_res = '0;
`endif

  div_fix u_fix (
    .i_raw      (bus.arr_result),
    .i_dividend (r_op1),
    .i_divisor  (r_op2),
    .o_result   (w_fixed)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state and state-decoded outputs; cancel always wins
  always_comb begin
    w_next        = r_state;
    bus.busy      = (r_state != S_IDLE);
    bus.done      = (r_state == S_DONE);
    bus.arr_en    = (r_state == S_WAIT);
    bus.stall_req = (r_state != S_IDLE) & (r_state != S_DONE);
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_byp ? S_DONE : S_WAIT;
      S_WAIT: if (r_cnt == '0) w_next = S_CORR;
      S_CORR: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.cancel) w_next = S_IDLE;
  end

  // operand latch, settle counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op1 <= bus.dividend;
        r_op2 <= bus.divisor;
        r_cnt <= CNT_W'(LATENCY - 1);
        if (w_byp) r_result <= w_byp_res;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == S_CORR && !bus.cancel) r_result <= w_fixed;
    end
  end

  assign bus.arr_op1 = r_op1;
  assign bus.arr_op2 = r_op2;
  assign bus.result  = r_result;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with LATENCY=4; the array is stood in for by a
// hand-picked raw {rem, quo} per operation.
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          tests = 0;
  int          fails = 0;
  logic [63:0] tb_raw = '0;
  int          n;

  div_ctrl_if u_if ();

  div_ctrl #(.LATENCY(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  assign u_if.arr_result = tb_raw;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
    bit byp = 1'b0;
`ifdef DIV_BYPASS_EN
    byp = 1'b1;
`endif
    return (byp && (b == 32'd0 || a == 32'd0 || b == 32'd1)) ? 1 : 6;
  endfunction

  // one full operation from an IDLE cycle, ending in the following IDLE cycle
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] raw, input logic [63:0] exp);
    int cnt, stalls, ens, lat;
    lat = exp_lat(a, b);
    tb_raw = raw;
    u_if.dividend = a;
    u_if.divisor  = b;
    u_if.start    = 1'b1;
    tick;
    u_if.start = 1'b0;
    cnt = 1; stalls = 0; ens = 0;
    while (!u_if.done && cnt < 40) begin
      if (u_if.stall_req) stalls++;
      if (u_if.arr_en && u_if.arr_op1 === a && u_if.arr_op2 === b) ens++;
      tick;
      cnt++;
    end
    chk({tag, ".lat"}, 64'(cnt), 64'(lat));
    chk({tag, ".res"}, u_if.result, exp);
    chk({tag, ".stall_cnt"}, 64'(stalls), 64'(lat - 1));
    chk({tag, ".stall_at_done"}, 64'(u_if.stall_req), 64'd0);
    chk({tag, ".arr_en_cnt"}, 64'(ens), 64'((lat == 1) ? 0 : lat - 2));
    tick;
    chk({tag, ".idle"}, 64'({u_if.done, u_if.busy}), 64'd0);
  endtask

  initial begin
    u_if.start = 1'b0; u_if.cancel = 1'b0;
    u_if.dividend = '0; u_if.divisor = '0;

    // reset state
    #12;
    chk("rst.ctl", 64'({u_if.busy, u_if.stall_req, u_if.done, u_if.arr_en}), 64'd0);
    chk("rst.ops", {u_if.arr_op1, u_if.arr_op2}, 64'd0);
    chk("rst.res", u_if.result, 64'd0);
    rst_n = 1'b1;
    tick;

    // correction paths: raw values deliberately off by one step
    run_div("p100_7",   32'd100,        32'd7,          {32'hFFFF_FFFB, 32'h0000_000F}, {32'h0000_0002, 32'h0000_000E});
    run_div("m100_7",   32'hFFFF_FF9C,  32'd7,          {32'h0000_0005, 32'hFFFF_FFF1}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    run_div("p100_m7",  32'd100,        32'hFFFF_FFF9,  {32'hFFFF_FFFB, 32'hFFFF_FFF1}, {32'h0000_0002, 32'hFFFF_FFF2});
    run_div("p14_7",    32'd14,         32'd7,          {32'h0000_0007, 32'h0000_0001}, {32'h0000_0000, 32'h0000_0002});
    run_div("m14_7",    32'hFFFF_FFF2,  32'd7,          {32'hFFFF_FFF9, 32'hFFFF_FFFF}, {32'h0000_0000, 32'hFFFF_FFFE});
    // special cases override whatever the array reports
    run_div("intmin",   32'h8000_0000,  32'hFFFF_FFFF,  64'h1234_5678_9ABC_DEF0,        {32'h0000_0000, 32'h8000_0000});
    run_div("div0",     32'd5,          32'd0,          64'hDEAD_BEEF_0BAD_F00D,        {32'h0000_0005, 32'hFFFF_FFFF});
    run_div("zero_9",   32'd0,          32'd9,          64'd0,                          64'd0);
    run_div("p77_1",    32'd77,         32'd1,          {32'd0, 32'd77},                {32'd0, 32'd77});

    // cancel in the second WAIT cycle
    tb_raw = {32'd0, 32'd10};
    u_if.dividend = 32'd50; u_if.divisor = 32'd5; u_if.start = 1'b1;
    tick;
    u_if.start = 1'b0;
    tick;
    u_if.cancel = 1'b1;
    tick;
    u_if.cancel = 1'b0;
    chk("cancel.busy_done", 64'({u_if.busy, u_if.done}), 64'd0);
    chk("cancel.res_kept", u_if.result, {32'd0, 32'd77});
    tick;
    run_div("after_cancel", 32'd49, 32'd7, {32'd0, 32'd7}, {32'd0, 32'd7});

    // second start during WAIT is dropped
    tb_raw = {32'hFFFF_FFFB, 32'h0000_000F};
    u_if.dividend = 32'd100; u_if.divisor = 32'd7; u_if.start = 1'b1;
    tick;
    u_if.start = 1'b0; n = 1;
    tick; n++;
    u_if.dividend = 32'd8; u_if.divisor = 32'd2; u_if.start = 1'b1;
    tick; n++;
    u_if.start = 1'b0;
    chk("ign.ops", {u_if.arr_op2, u_if.arr_op1}, {32'd7, 32'd100});
    while (!u_if.done && n < 40) begin
      tick; n++;
    end
    chk("ign.lat", 64'(n), 64'd6);
    chk("ign.res", u_if.result, {32'h0000_0002, 32'h0000_000E});
    tick;
    run_div("b2b_9_3", 32'd9, 32'd3, {32'd0, 32'd3}, {32'd0, 32'd3});

    // reset dropped while in CORR
    tb_raw = {32'hFFFF_FFFB, 32'h0000_000F};
    u_if.dividend = 32'd100; u_if.divisor = 32'd7; u_if.start = 1'b1;
    tick;
    u_if.start = 1'b0;
    repeat (4) tick;
    chk("rst_corr.pre", 64'({u_if.busy, u_if.stall_req, u_if.arr_en, u_if.done}), 64'b1100);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_corr.ctl", 64'({u_if.busy, u_if.stall_req, u_if.done, u_if.arr_en}), 64'd0);
    chk("rst_corr.res", u_if.result, 64'd0);
    chk("rst_corr.ops", {u_if.arr_op1, u_if.arr_op2}, 64'd0);
    tick;
    chk("rst_corr.no_done", 64'(u_if.done), 64'd0);
    rst_n = 1'b1;
    tick;
    run_div("post_rst", 32'd49, 32'd7, {32'd0, 32'd7}, {32'd0, 32'd7});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
